// File: rtl/despread.sv
// -----------------------------------------------------------------------------
// despread
//   Receive-side chip despreader. After reset it records SPREAD chips of the
//   same pseudo-random code the spreader uses, taken from its own lfsr
//   instance. It then XORs each received chip with the matching code chip and
//   counts the ones over one symbol. A majority vote over the symbol gives
//   the recovered information bit.
//
// Ports
//   i_clk      clock (single domain)
//   i_reset_n  asynchronous active-low reset
//   o_ready    code table loaded, chips are accepted from now on
//   i_data     received chip
//   i_valid    i_data valid this cycle
//   i_sync     current chip is chip 0 of a new symbol
//   o_data     recovered information bit (held until the next decision)
//   o_valid    one-cycle pulse: o_data / o_corr carry a new decision
//   o_corr     number of despread ones in the symbol just decided
// -----------------------------------------------------------------------------
module despread #(
  parameter int SPREAD       = 24,
  parameter int SIZE_COUNTER = $clog2(SPREAD),
  parameter int SIZE_CORR    = $clog2(SPREAD + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  output logic                 o_ready,
  input  logic                 i_data,
  input  logic                 i_valid,
  input  logic                 i_sync,
  output logic                 o_data,
  output logic                 o_valid,
  output logic [SIZE_CORR-1:0] o_corr
);

  localparam logic [SIZE_COUNTER-1:0] LAST_IDX = SIZE_COUNTER'(SPREAD - 1);
  localparam logic [SIZE_CORR-1:0]    HALF     = SIZE_CORR'(SPREAD / 2);

  // Code generator: same polynomial and seed as the spreader, so loading it
  // chip by chip reproduces the spreader's chip order exactly.
  logic lfsr_reset;
  logic lfsr_chip;

  assign lfsr_reset = ~i_reset_n;

  logic load_en_q, load_en_d;

  lfsr #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .SEED  (8'hA5)
  ) u_lfsr (
    .i_clk       (i_clk),
    .i_reset     (lfsr_reset),
    .i_valid     (load_en_q),
    .o_lfsr_data (lfsr_chip)
  );

  logic [SIZE_COUNTER-1:0] load_cnt_q, load_cnt_d;
  logic [SPREAD-1:0]       code_q, code_d;
  logic                    ready_q, ready_d;
  logic [SIZE_COUNTER-1:0] chip_cnt_q, chip_cnt_d;
  logic [SIZE_CORR-1:0]    acc_q, acc_d;
  logic                    valid_q, valid_d;
  logic                    data_q, data_d;
  logic [SIZE_CORR-1:0]    corr_q, corr_d;

  // Per-chip working values.
  logic                    start;
  logic [SIZE_COUNTER-1:0] idx;
  logic                    d_chip;
  logic [SIZE_CORR-1:0]    sum;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis would infer a latch to hold the old value.
    load_en_d  = load_en_q;
    load_cnt_d = load_cnt_q;
    code_d     = code_q;
    ready_d    = ready_q | ~load_en_q;
    chip_cnt_d = chip_cnt_q;
    acc_d      = acc_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    corr_d     = corr_q;
    start      = 1'b0;
    idx        = '0;
    d_chip     = 1'b0;
    sum        = '0;

    if (load_en_q) begin
      code_d[load_cnt_q] = lfsr_chip;
      load_cnt_d         = load_cnt_q + 1'b1;
      if (load_cnt_q == LAST_IDX) begin
        load_en_d = 1'b0;
      end
    end

    if (ready_q && i_valid) begin
      // i_sync restarts the symbol at any index; a partial symbol is dropped.
      start  = (chip_cnt_q == '0) || i_sync;
      idx    = start ? '0 : chip_cnt_q;
      d_chip = i_data ^ code_q[idx];
      sum    = start ? SIZE_CORR'(d_chip) : acc_q + SIZE_CORR'(d_chip);
      acc_d  = sum;
      if (idx == LAST_IDX) begin
        chip_cnt_d = '0;
        valid_d    = 1'b1;
        corr_d     = sum;
        data_d     = (sum > HALF);  // a tie decides 0
      end else begin
        chip_cnt_d = idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      load_en_q  <= 1'b1;
      load_cnt_q <= '0;
      // NOTE: the code table is small flop storage, reset so that the
      // reset state is fully defined; a RAM-style table would not be.
      code_q     <= '0;
      ready_q    <= 1'b0;
      chip_cnt_q <= '0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
      corr_q     <= '0;
    end else begin
      load_en_q  <= load_en_d;
      load_cnt_q <= load_cnt_d;
      code_q     <= code_d;
      ready_q    <= ready_d;
      chip_cnt_q <= chip_cnt_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      corr_q     <= corr_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_corr  = corr_q;

endmodule

// -----------------------------------------------------------------------------
// lfsr
//   Fibonacci LFSR shared with the spreader. Held at SEED while i_reset is
//   high; advances one step on each clock with i_valid=1. o_lfsr_data is the
//   MSB of the current state.
//
// Ports
//   i_clk        clock
//   i_reset      asynchronous active-high reset
//   i_valid      advance enable
//   o_lfsr_data  current code chip
// -----------------------------------------------------------------------------
module lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_valid,
  output logic o_lfsr_data
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (i_valid) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_lfsr_data = state_q[WIDTH-1];

endmodule

// File: doc/despread.md
# despread

Receive-side counterpart of the spreading block: it takes the chip stream that the spreader produces and regenerates the same pseudo-random spreading code from an identical `lfsr` instance. Each chip is XORed with the code. The block counts despread ones over one symbol period of SPREAD chips and makes a majority decision to recover one information bit. It sits after chip synchronisation and ahead of the bit-level deframer.

## Interface
- SPREAD, 24, chips per information bit; must match the spreader.
- SIZE_COUNTER, $clog2(SPREAD), width of the chip index counters.
- SIZE_CORR, $clog2(SPREAD+1), width of the correlation count, which ranges 0..SPREAD.

Ports:
- i_clk  input  1  clock. One clock domain only.
- i_reset_n  input  1  asynchronous, active-low reset.
- o_ready  output  1  code loaded; chips are accepted.
- i_data  input  1  received chip.
- i_valid  input  1  i_data is valid this cycle.
- i_sync  input  1  marks the current chip as chip 0 of a new symbol.
- o_data  output  1  recovered information bit.
- o_valid  output  1  one-cycle pulse; o_data and o_corr are valid.
- o_corr  output  SIZE_CORR  number of despread ones in the symbol just decided.

## Operation
- **lfsr instance:** one `lfsr` instance with the same taps and seed as the spreader.
  - Its reset is driven by ~i_reset_n.
  - Its i_valid is driven by an internal load-enable.
- **Code load:**
  - The load-enable is 1 while reset is asserted and stays 1 after release.
  - Each clock edge with load-enable 1 stores o_lfsr_data into code[load_cnt] and increments load_cnt.
  - The edge that stores code[SPREAD-1] clears load-enable.
  - This gives the same chip order the spreader uses.
- **o_ready:** rises on the edge after load-enable falls, then stays 1 until reset.
- **Chips before ready:** while o_ready=0, i_valid, i_data and i_sync are ignored.
- **Accepting a chip:** with o_ready=1 and i_valid=1 the block forms d = i_data ^ code[chip_cnt].
  - If chip_cnt==0 or i_sync=1: chip index is treated as 0, acc <= d, chip_cnt <= 1.
  - Otherwise: acc <= acc + d; chip_cnt <= chip_cnt+1.
  - When the accepted chip has index SPREAD-1:
    - chip_cnt <= 0.
    - The decision is registered: o_corr <= acc+d, o_data <= ((acc+d) > SPREAD/2), o_valid <= 1.
- **Majority rule:** a tie (exactly SPREAD/2) decides 0.
- **Gaps:** cycles with i_valid=0 hold chip_cnt and acc. Gaps of any length inside a symbol are allowed.
- **i_sync mid-symbol:** the partial symbol is discarded with no o_valid, and the current chip starts a new symbol.
- **i_sync on the last chip:** i_sync=1 with chip_cnt==SPREAD-1 makes the chip chip 0. No decision is produced.
- **i_sync with i_valid=0:** ignored.
- **Arithmetic:** acc is SIZE_CORR bits wide and cannot overflow, since its maximum is SPREAD.

## Timing
- **Reset values:** o_ready=0, o_valid=0, o_data=0, o_corr=0, chip_cnt=0, acc=0, load_cnt=0, code=0.
- **Code load after reset release:**
  - Code chips are captured on edges 1..SPREAD.
  - o_ready=1 after edge SPREAD+1.
- **Decision latency:** o_valid is high for exactly one cycle, the cycle after the edge that samples chip SPREAD-1.
- **Output hold:** o_data and o_corr hold their values until the next decision.
- **Throughput:** back-to-back symbols at one chip per clock. The next symbol's chip 0 may be sampled in the same cycle o_valid is high.
- **No backpressure:** the consumer must accept o_valid pulses when they occur.
- **Reset mid-operation:**
  - All state returns to reset values immediately (asynchronously).
  - Any in-flight symbol is lost and no o_valid is produced.
  - The code is reloaded, and o_ready returns SPREAD+1 edges after release.

## Test plan
- **Reset and load:** hold i_reset_n=0 for 3 cycles, then release.
  - All outputs are 0 during reset.
  - o_ready=1 exactly after edge 25 (SPREAD=24).
  - The internal code equals the spreader's code bit-for-bit.
- **Loopback:** spreader output feeds despread, bits 1,0,1,1 back-to-back with i_sync on the first chip.
  - o_data = 1,0,1,1.
  - o_corr = 24,0,24,24.
  - o_valid pulses 24 cycles apart.
- **Chip errors:** bit 1 with 5 chips inverted gives o_data=1, o_corr=19. Bit 1 with 12 chips inverted gives o_data=0, o_corr=12 (tie decides 0).
- **Gapped input:** bit 0 with i_valid low for 3 cycles after every 4th chip gives a single o_valid with o_data=0, o_corr=0, one cycle after the 24th valid chip.
- **Resync:** i_sync asserted on chip 10 of a symbol.
  - No o_valid for the partial symbol.
  - The next 24 chips decode correctly.
  - i_sync while i_valid=0 has no effect.
- **Reset mid-symbol:** i_reset_n pulsed low at chip 15.
  - Outputs return to 0 immediately.
  - No o_valid appears.
  - o_ready returns 25 edges after release, and the subsequent loopback decodes correctly.
